// File: rtl/blit_pkg.sv
// Shared blitter types and sizes: phrase/address widths, write-buffer depth,
// write-buffer FSM states and the queued entry layout.
package blit_pkg;

   localparam int PHRASE_W   = 64;
   localparam int PADDR_W    = 21;
   localparam int WBUF_DEPTH = 4;

   typedef enum logic [0:0] {
      WB_IDLE = 1'b0,
      WB_REQ  = 1'b1
   } wb_state_t;

   typedef struct packed {
      logic [PADDR_W-1:0]  addr;
      logic [PHRASE_W-1:0] data;
   } wbuf_entry_t;

endpackage

// File: rtl/blit_wbuf_fifo.sv
// Register FIFO for the blitter write buffer: push/pop, clear with optional
// retention of the head entry, head read and occupancy count.
module blit_wbuf_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 85,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          sys_clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic [W-1:0]  wr_data,
   input  logic          pop,
   input  logic          clear,
   input  logic          keep_head,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;

   always_ff @(posedge sys_clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         // Keeping the head means the tail collapses onto the slot after it.
         if (keep_head) begin
            wr_ptr <= rd_ptr + PW'(1);
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
               cnt    <= '0;
            end else begin
               cnt    <= CW'(1);
            end
         end else begin
            wr_ptr <= rd_ptr;
            cnt    <= '0;
         end
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + CW'(1);
         end else if (pop && !push) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   assign head  = mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/blit_wbuf.sv
// Blitter write buffer: queues finished write phrases and drains them to the
// memory controller over mreq/mack so the blitter inner loop is not held off.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WB_IDLE | no bus request; waits for a queued entry
// WB_REQ  | mreq high, head entry presented until mack pops it
module blit_wbuf
   import blit_pkg::*;
#(
   parameter int DEPTH = WBUF_DEPTH,
   parameter int AW    = PADDR_W
) (
   input  logic                         sys_clk,
   input  logic                         reset_n,
   input  logic                         push,
   input  logic                         wdata_oe,
   input  logic [PHRASE_W-1:0]          wdata_in,
   input  logic [AW-1:0]                waddr,
   input  logic                         flush,
   output logic                         stall,
   output logic                         idle,
   output logic                         mreq,
   output logic [AW-1:0]                maddr,
   output logic [PHRASE_W-1:0]          mdata,
   input  logic                         mack,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = AW + PHRASE_W;

   wb_state_t     state;
   logic          mreq_q;
   logic          accept;
   logic          pop;
   logic [CW-1:0] fifo_count;
   logic [EW-1:0] head;

   assign accept = push && wdata_oe && !stall && !flush;
   assign pop    = (state == WB_REQ) && mack;

   blit_wbuf_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .reset_n   (reset_n),
      .push      (accept),
      .wr_data   ({waddr, wdata_in}),
      .pop       (pop),
      .clear     (flush),
      .keep_head (state == WB_REQ),
      .head      (head),
      .count     (fifo_count)
   );

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= WB_IDLE;
         mreq_q <= 1'b0;
      end else begin
         case (state)
            WB_IDLE: begin
               if (fifo_count != '0 && !flush) begin
                  state  <= WB_REQ;
                  mreq_q <= 1'b1;
               end
            end
            WB_REQ: begin
               // Leave only when the pop empties the buffer (a flush with
               // the pop discards everything behind the head).
               if (mack && (flush || (fifo_count == CW'(1) && !accept))) begin
                  state  <= WB_IDLE;
                  mreq_q <= 1'b0;
               end
            end
            default: begin
               state  <= WB_IDLE;
               mreq_q <= 1'b0;
            end
         endcase
      end
   end

   assign mreq  = mreq_q;
   assign maddr = mreq_q ? head[EW-1:PHRASE_W] : '0;
   assign mdata = mreq_q ? head[PHRASE_W-1:0]  : '0;
   assign stall = (fifo_count == CW'(DEPTH));
   assign idle  = (fifo_count == '0) && (state == WB_IDLE);
   assign count = fifo_count;

endmodule

// File: tb/tb_blit_wbuf.sv
// Self-checking bench for blit_wbuf: directed scenarios plus random traffic,
// scored against a queue-based reference model of the write buffer.
module tb_blit_wbuf;
   import blit_pkg::*;

   localparam int DEPTH = WBUF_DEPTH;
   localparam int AW    = PADDR_W;
   localparam int CW    = $clog2(DEPTH + 1);

   logic                sys_clk  = 1'b0;
   logic                reset_n  = 1'b0;
   logic                push     = 1'b0;
   logic                wdata_oe = 1'b0;
   logic [63:0]         wdata_in = '0;
   logic [AW-1:0]       waddr    = '0;
   logic                flush    = 1'b0;
   logic                mack     = 1'b0;
   logic                stall;
   logic                idle;
   logic                mreq;
   logic [AW-1:0]       maddr;
   logic [63:0]         mdata;
   logic [CW-1:0]       count;

   blit_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
      .sys_clk  (sys_clk),
      .reset_n  (reset_n),
      .push     (push),
      .wdata_oe (wdata_oe),
      .wdata_in (wdata_in),
      .waddr    (waddr),
      .flush    (flush),
      .stall    (stall),
      .idle     (idle),
      .mreq     (mreq),
      .maddr    (maddr),
      .mdata    (mdata),
      .mack     (mack),
      .count    (count)
   );

   always #5 sys_clk = ~sys_clk;

   int          checks = 0;
   int          errors = 0;
   wbuf_entry_t sb_q[$];
   int          m_count = 0;
   bit          m_req   = 1'b0;
   bit          cur_acc = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Issue one cycle of stimulus; expected entries go to the scoreboard here.
   task automatic drive(input bit p, input bit oe, input logic [AW-1:0] a,
                        input logic [63:0] d, input bit f, input bit k);
      @(posedge sys_clk);
      #1;
      push     = p;
      wdata_oe = oe;
      waddr    = a;
      wdata_in = d;
      flush    = f;
      mack     = k;
      cur_acc  = p && oe && !f && (m_count < DEPTH);
      if (cur_acc) sb_q.push_back('{addr: a, data: d});
      if (f) begin
         if (m_req) begin
            while (sb_q.size() > 1) void'(sb_q.pop_back());
         end else begin
            sb_q.delete();
         end
      end
   endtask

   task automatic idle_cycles(input int n, input bit k);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, k);
   endtask

   // Monitor and model: compares DUT outputs, pops the scoreboard on handshakes.
   always @(negedge sys_clk) begin
      if (!reset_n) begin
         check("rst_mreq", mreq, 0);
         check("rst_maddr", maddr, 0);
         check("rst_mdata", mdata, 0);
         check("rst_count", count, 0);
         check("rst_stall", stall, 0);
         check("rst_idle", idle, 1);
         sb_q.delete();
         m_count = 0;
         m_req   = 1'b0;
         cur_acc = 1'b0;
      end else begin
         int nc;
         bit pop_now;
         check("count", count, m_count);
         check("stall", stall, m_count == DEPTH);
         check("idle", idle, (m_count == 0) && !m_req);
         check("mreq", mreq, m_req);
         pop_now = m_req && mack;
         if (m_req) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty: request expected with empty scoreboard (t=%0t)", $time);
            end else begin
               check("maddr", maddr, sb_q[0].addr);
               check("mdata", mdata, sb_q[0].data);
               if (pop_now) void'(sb_q.pop_front());
            end
         end
         if (flush) nc = (m_req && !pop_now) ? 1 : 0;
         else       nc = m_count + int'(cur_acc) - int'(pop_now);
         m_req   = m_req ? (nc != 0) : (m_count != 0 && !flush);
         m_count = nc;
      end
   end

   initial begin
      repeat (3) @(posedge sys_clk);
      #1 reset_n = 1'b1;

      // single write, mack in cycle 4
      drive(1, 1, 21'h000010, 64'h0123456789ABCDEF, 0, 0);
      idle_cycles(3, 0);
      drive(0, 0, '0, '0, 0, 1);
      idle_cycles(2, 0);
      check("single_done_idle", idle, 1);

      // push without output enable
      for (int i = 0; i < 3; i++) drive(1, 0, AW'($urandom), {$urandom, $urandom}, 0, 0);
      idle_cycles(2, 0);
      check("gate_count", count, 0);

      // fill, overflow attempt, drain
      for (int i = 1; i <= 4; i++) drive(1, 1, AW'(i), 64'(i), 0, 0);
      drive(1, 1, AW'(5), 64'd5, 0, 0);
      check("fill_stall", stall, 1);
      check("fill_count", count, 4);
      idle_cycles(4, 1);
      idle_cycles(2, 0);
      check("drain_count", count, 0);

      // simultaneous push and pop at count 2
      drive(1, 1, 21'h100, 64'hA, 0, 0);
      drive(1, 1, 21'h101, 64'hB, 0, 0);
      drive(1, 1, 21'h102, 64'hC, 0, 1);
      check("simul_count_before", count, 2);
      drive(0, 0, '0, '0, 0, 0);
      check("simul_count_after", count, 2);
      idle_cycles(3, 1);
      idle_cycles(1, 0);

      // flush while requesting entry A
      drive(1, 1, 21'h0AAAA, 64'hAAAA_0000_AAAA_0000, 0, 0);
      drive(1, 1, 21'h0BBBB, 64'hBBBB, 0, 0);
      drive(1, 1, 21'h0CCCC, 64'hCCCC, 0, 0);
      idle_cycles(1, 0);
      drive(0, 0, '0, '0, 1, 0);
      idle_cycles(1, 0);
      check("flush_count", count, 1);
      check("flush_maddr", maddr, 21'h0AAAA);
      drive(0, 0, '0, '0, 0, 1);
      idle_cycles(1, 0);
      check("flush_idle", idle, 1);

      // reset while a request is outstanding
      drive(1, 1, 21'h1F00F, 64'hDEAD_BEEF, 0, 0);
      idle_cycles(2, 0);
      check("prereset_mreq", mreq, 1);
      @(posedge sys_clk);
      #1;
      push = 0; wdata_oe = 0; flush = 0; mack = 0; cur_acc = 0;
      reset_n = 1'b0;
      #1;
      check("async_rst_mreq", mreq, 0);
      check("async_rst_count", count, 0);
      @(posedge sys_clk);
      #1 reset_n = 1'b1;
      idle_cycles(4, 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bit k;
         k = (i % 600 < 100) ? 1'b1 : 1'(($urandom % 3) != 0);
         drive(1'(($urandom % 3) != 0), 1'(($urandom % 5) != 0), AW'($urandom),
               {$urandom, $urandom}, 1'(($urandom % 40) == 0), k);
      end
      idle_cycles(DEPTH + 4, 1);
      check("final_idle", idle, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/blit_wbuf.md
# blit_wbuf

Blitter write buffer, directly downstream of the blitter data multiplexer. It captures each finished 64-bit write phrase (`wdata_out`/`wdata_oe`) together with its phrase address into a small FIFO. It drains the FIFO to the memory controller over a req/ack handshake, so the blitter inner loop can keep running while the bus is busy. It back-pressures the blitter with `stall` when full and reports `idle` for blit completion.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `AW`, 21, phrase address width (byte address bits [23:3])

Ports:
- `sys_clk`  in  1  system clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `push`  in  1  blitter write strobe for the current phrase
- `wdata_oe`  in  1  data mux output enable; qualifies `push`
- `wdata_in`  in  64  phrase from data mux (`wdata_out`)
- `waddr`  in  AW  phrase address of the write
- `flush`  in  1  discard all queued, un-issued entries
- `stall`  out  1  FIFO full; blitter must not push
- `idle`  out  1  FIFO empty and no request outstanding
- `mreq`  out  1  memory write request
- `maddr`  out  AW  request phrase address
- `mdata`  out  64  request phrase data
- `mack`  in  1  single-cycle accept of the current request
- `count`  out  $clog2(DEPTH+1)  entries held, including the one being requested

## Operation
- Accept: `push & wdata_oe & ~stall` writes {`waddr`, `wdata_in`} at tail. `push` with `wdata_oe`=0 or `stall`=1 is ignored; nothing is stored and no error is raised.
- FSM states:
  - `IDLE` (`mreq`=0): go to `REQ` when `count`!=0.
  - `REQ` (`mreq`=1, `maddr`/`mdata` = head entry, held stable until `mack`): on `mack`, head pops. Stay in `REQ` if one or more entries remain after the pop; otherwise go to `IDLE`.
- `mack` while in `IDLE` is ignored.
- `count` arithmetic:
  - +1 on accept, -1 on `mack` in `REQ`.
  - Simultaneous accept and pop: unchanged.
  - Pointers wrap modulo DEPTH.
- `stall` = (`count`==DEPTH), from registered state. A pop in the same cycle does not unblock a push; the push is retried next cycle.
- `flush`:
  - In `IDLE`: clears all entries.
  - In `REQ`: keeps only the head entry being requested, because a started bus request is never withdrawn. That entry completes normally on `mack`.
  - A push in the flush cycle is discarded.
- `idle` = `count`==0 & state==`IDLE`.

## Timing
- Reset values: `mreq`=0, `maddr`=0, `mdata`=0, `stall`=0, `idle`=1, `count`=0, state `IDLE`, pointers 0.
- Reset asserted mid-request drops `mreq` immediately (asynchronously) and loses all entries.
- Latency: accept in cycle N puts `count` update and `idle`=0 in N+1. `mreq`=1 with the entry follows in N+2 (IDLE→REQ registered).
- Throughput: `mreq` may stay high across back-to-back entries, giving one phrase per cycle when `mack` is held high every cycle.
- After `mack` in cycle M, `maddr`/`mdata` show the next head in M+1; `mreq` falls in M+1 if empty.
- All outputs are registered or decoded from registered state; no combinational path from `push`/`mack` to any output.

## Structure
- Shared package `blit_pkg`: `PHRASE_W`=64, `PADDR_W`=21, `WBUF_DEPTH`=4, FSM state enum {`WB_IDLE`, `WB_REQ`}, entry struct {addr, data}.
- One sub-module `blit_wbuf_fifo`: synchronous DEPTH×(AW+64) register FIFO providing push/pop/clear-keep-head, head read, count.
- The top level holds the FSM, flush handling, and output registers.

## Test plan
- Single write: push addr 0x000010, data 0x0123456789ABCDEF with `wdata_oe`=1 at cycle 0; `mack` at cycle 4 → `mreq` rises cycle 2 with that addr/data, falls cycle 5; `idle` is 0 in cycles 1-4 and returns to 1 in cycle 5.
- Gating: `push`=1 with `wdata_oe`=0 → `count` stays 0, `mreq` never asserts.
- Fill and stall: 4 pushes with `mack` held 0 → `stall`=1, `count`=4. A 5th push is ignored. Then `mack`=1 for 4 cycles → data drains in order 1,2,3,4, `stall` clears after the first pop, final `count`=0.
- Simultaneous push and pop at `count`=2 → `count` stays 2 and FIFO order is preserved.
- Flush: 3 entries queued, `mreq` high on entry A, `flush` pulsed → `count`=1, A still presented; after `mack`, `idle`=1.
- Reset mid-request: `reset_n` low while `mreq`=1 → `mreq`=0 that cycle, `count`=0. After release, no request until a new push.
